// File: rtl/sync_ram_pipe_pkg.sv
// Shared constants for sync_ram_pipe: default word width, FSM encodings and read-latency bound.
// Build option MEM_PARITY_EN adds one stored even-parity bit per word.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

package sync_ram_pipe_pkg;

  localparam int DEFAULT_DATA_WIDTH = `DATA_WIDTH;
  localparam int MAX_READ_LATENCY   = 4;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

`ifdef MEM_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

endpackage

// File: rtl/sync_ram_pipe_rd_pipe.sv
// Read-return shift pipeline: LATENCY stages of valid + word, stage 0 loaded at the accept edge.
// Asynchronous active-low clear empties every stage so no stale word survives a reset.
module rd_pipe #(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic [LATENCY-1:0]            valid_reg;
  logic [LATENCY-1:0][WIDTH-1:0] data_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_reg <= '0;
      data_reg  <= '0;
    end else begin
      valid_reg[0] <= in_valid;
      data_reg[0]  <= in_data;
      for (int i = 1; i < LATENCY; i++) begin
        valid_reg[i] <= valid_reg[i-1];
        data_reg[i]  <= data_reg[i-1];
      end
    end
  end

  assign out_valid = valid_reg[LATENCY-1];
  assign out_data  = data_reg[LATENCY-1];

endmodule

// File: rtl/sync_ram_pipe.sv
// Single-port synchronous RAM on a shared tri-state bus with a post-reset clear sweep and a
// pipelined read return. Define MEM_PARITY_EN to store and check an even-parity bit per word.
module sync_ram_pipe
  import sync_ram_pipe_pkg::*;
#(
  parameter int                    DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int                    DEPTH        = 256,
  parameter int                    ADDR_WIDTH   = $clog2(DEPTH),
  parameter int                    READ_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE  = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  CS,
  input  logic                  RD_WR,
  input  logic [ADDR_WIDTH-1:0] address,
  inout  wire  [DATA_WIDTH-1:0] data,
  output logic                  ready,
  output logic                  rvalid,
  output logic                  par_err
);

  localparam int LAT = (READ_LATENCY < 1) ? 1 :
                       (READ_LATENCY > MAX_READ_LATENCY) ? MAX_READ_LATENCY : READ_LATENCY;
  localparam int                    MEM_WIDTH = DATA_WIDTH + PARITY_BITS;
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  logic [0:0]            state_reg;
  logic [ADDR_WIDTH-1:0] ptr_reg;
  logic [MEM_WIDTH-1:0]  mem [DEPTH];

  logic                  clearing;
  logic                  in_range;
  logic                  wr_accept;
  logic                  rd_accept;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [MEM_WIDTH-1:0]  mem_wdata;
  logic [MEM_WIDTH-1:0]  rd_word;
  logic [MEM_WIDTH-1:0]  pipe_word;

  assign clearing  = (state_reg == ST_CLEAR);
  assign in_range  = ({1'b0, address} < DEPTH_EXT);
  // A write in the rvalid cycle would fight the RAM's own drive on the bus, so it is held off.
  assign ready     = ~clearing & ~(rvalid & CS & ~RD_WR);
  assign wr_accept = ready & CS & ~RD_WR;
  assign rd_accept = ready & CS & RD_WR;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_CLEAR;
      ptr_reg   <= '0;
    end else if (clearing) begin
      ptr_reg <= ptr_reg + 1'b1;
      if (ptr_reg == LAST_ADDR) begin
        state_reg <= ST_RUN;
        ptr_reg   <= '0;
      end
    end
  end

  // The clear sweep and bus writes share the one write port.
  assign wr_data   = clearing ? CLEAR_VALUE : data;
  assign mem_we    = clearing | (wr_accept & in_range);
  assign mem_waddr = clearing ? ptr_reg : address;

`ifdef MEM_PARITY_EN
  assign mem_wdata = {^wr_data, wr_data};
`else
  assign mem_wdata = wr_data;
`endif

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign rd_word = in_range ? mem[address] : '0;

  rd_pipe #(
    .WIDTH   (MEM_WIDTH),
    .LATENCY (LAT)
  ) u_rd_pipe (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (rd_accept),
    .in_data   (rd_word),
    .out_valid (rvalid),
    .out_data  (pipe_word)
  );

  assign data = rvalid ? pipe_word[DATA_WIDTH-1:0] : {DATA_WIDTH{1'bz}};

`ifdef MEM_PARITY_EN
  assign par_err = rvalid & ((^pipe_word[DATA_WIDTH-1:0]) != pipe_word[DATA_WIDTH]);
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_sync_ram_pipe.sv
// Directed bench for sync_ram_pipe: dut_a is DEPTH=8 / latency 1, dut_b is DEPTH=6 / latency 3.
// Build with MEM_PARITY_EN defined to add the parity corruption sequence.
module tb_sync_ram_pipe;

  logic clk;
  logic reset;

  logic       cs_a, rw_a, ready_a, rvalid_a, perr_a;
  logic [2:0] addr_a;
  logic [7:0] wd_a;
  wire  [7:0] data_a;

  logic       cs_b, rw_b, ready_b, rvalid_b, perr_b;
  logic [2:0] addr_b;
  logic [7:0] wd_b;
  wire  [7:0] data_b;

  int checks = 0;
  int errors = 0;

  // The master only drives write data while the RAM is not returning a word.
  assign data_a = (cs_a & ~rw_a & ~rvalid_a) ? wd_a : 8'hzz;
  assign data_b = (cs_b & ~rw_b & ~rvalid_b) ? wd_b : 8'hzz;

  sync_ram_pipe #(.DATA_WIDTH(8), .DEPTH(8), .READ_LATENCY(1)) dut_a (
    .clk(clk), .reset(reset), .CS(cs_a), .RD_WR(rw_a), .address(addr_a),
    .data(data_a), .ready(ready_a), .rvalid(rvalid_a), .par_err(perr_a)
  );

  sync_ram_pipe #(.DATA_WIDTH(8), .DEPTH(6), .READ_LATENCY(3)) dut_b (
    .clk(clk), .reset(reset), .CS(cs_b), .RD_WR(rw_b), .address(addr_b),
    .data(data_b), .ready(ready_b), .rvalid(rvalid_b), .par_err(perr_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       cs;
    logic       rw;
    logic [2:0] addr;
    logic [7:0] wd;
    logic       exp_ready;
    logic       exp_rvalid;
    logic       chk_data;
    logic [7:0] exp_data;
  } vec_t;

  vec_t       vecs [18];
  logic [7:0] words [8] = '{8'h3C, 8'hA1, 8'h5F, 8'h07, 8'hE2, 8'h99, 8'h10, 8'hFF};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_a(input logic cs, input logic rw, input logic [2:0] ad, input logic [7:0] wd);
    @(posedge clk);
    #1;
    cs_a = cs; rw_a = rw; addr_a = ad; wd_a = wd;
    @(negedge clk);
    $display("a: cs=%b rw=%b addr=%0d ready=%b rvalid=%b data=%h par_err=%b",
             cs, rw, ad, ready_a, rvalid_a, data_a, perr_a);
  endtask

  task automatic drive_b(input logic cs, input logic rw, input logic [2:0] ad, input logic [7:0] wd);
    @(posedge clk);
    #1;
    cs_b = cs; rw_b = rw; addr_b = ad; wd_b = wd;
    @(negedge clk);
    $display("b: cs=%b rw=%b addr=%0d ready=%b rvalid=%b data=%h par_err=%b",
             cs, rw, ad, ready_b, rvalid_b, data_b, perr_b);
  endtask

  task automatic print_mem();
    for (int i = 0; i < 8; i++) $display("dut_a mem[%0d] = %h", i, dut_a.mem[i]);
  endtask

`ifdef MEM_PARITY_EN
  task automatic flip_bit(input int a, input int b);
    dut_a.mem[a][b] = ~dut_a.mem[a][b];
  endtask
`endif

  // A write must never be accepted in a cycle where read data is on the bus.
  always @(negedge clk) begin
    if (reset && cs_a && !rw_a && ready_a && rvalid_a) begin
      errors++;
      $display("FAIL wr_in_rvalid_a: ready=%b rvalid=%b required not both 1", ready_a, rvalid_a);
    end
    if (reset && cs_b && !rw_b && ready_b && rvalid_b) begin
      errors++;
      $display("FAIL wr_in_rvalid_b: ready=%b rvalid=%b required not both 1", ready_b, rvalid_b);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt_a, cnt_b, stale_b;

    for (int i = 0; i < 8; i++)
      vecs[i] = '{1'b1, 1'b0, 3'(i), words[i], 1'b1, 1'b0, 1'b1, words[i]};
    vecs[8] = '{1'b1, 1'b1, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00};
    for (int i = 1; i < 8; i++)
      vecs[8+i] = '{1'b1, 1'b1, 3'(i), 8'h00, 1'b1, 1'b1, 1'b1, words[i-1]};
    vecs[16] = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 1'b1, words[7]};
    vecs[17] = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00};

    // Reset state, with a write request held through the clear sweep
    reset = 1'b0;
    cs_a = 1'b1; rw_a = 1'b0; addr_a = 3'd0; wd_a = 8'h00;
    cs_b = 1'b1; rw_b = 1'b0; addr_b = 3'd0; wd_b = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst ready_a", ready_a, 1'b0);
    check("rst rvalid_a", rvalid_a, 1'b0);
    check("rst par_err_a", perr_a, 1'b0);
    check("rst ready_b", ready_b, 1'b0);
    check("rst rvalid_b", rvalid_b, 1'b0);
    @(posedge clk);
    #1 reset = 1'b1;
    cnt_a = 0; cnt_b = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!ready_a) cnt_a++;
      if (!ready_b) cnt_b++;
    end
    check("clear cycles a", cnt_a, 8);
    check("clear cycles b", cnt_b, 6);
    cs_a = 1'b0; cs_b = 1'b0;

    // Every location reads back as the clear value
    for (int k = 0; k < 9; k++) begin
      drive_a(k < 8, 1'b1, 3'(k), 8'h00);
      if (k > 0) begin
        check($sformatf("clr a rvalid %0d", k - 1), rvalid_a, 1'b1);
        check($sformatf("clr a data %0d", k - 1), data_a, 8'h00);
      end
    end
    for (int k = 0; k < 11; k++) begin
      drive_b(k < 8, 1'b1, 3'(k), 8'h00);
      if (k >= 3) begin
        check($sformatf("clr b rvalid %0d", k - 3), rvalid_b, 1'b1);
        check($sformatf("clr b data %0d", k - 3), data_b, 8'h00);
      end
    end

    // Write 0..7 then back-to-back reads, latency 1
    for (int i = 0; i < 18; i++) begin
      drive_a(vecs[i].cs, vecs[i].rw, vecs[i].addr, vecs[i].wd);
      check($sformatf("vec%0d ready", i), ready_a, vecs[i].exp_ready);
      check($sformatf("vec%0d rvalid", i), rvalid_a, vecs[i].exp_rvalid);
      check($sformatf("vec%0d par_err", i), perr_a, 1'b0);
      if (vecs[i].chk_data) check($sformatf("vec%0d data", i), data_a, vecs[i].exp_data);
    end
    print_mem();

    // Write requested during the rvalid cycle is refused, then commits when held
    drive_a(1'b1, 1'b1, 3'd2, 8'h00);
    check("t4 read ready", ready_a, 1'b1);
    drive_a(1'b1, 1'b0, 3'd2, 8'h6B);
    check("t4 wr ready in rvalid", ready_a, 1'b0);
    check("t4 rvalid", rvalid_a, 1'b1);
    check("t4 bus shows read", data_a, 8'h5F);
    drive_a(1'b1, 1'b0, 3'd2, 8'h6B);
    check("t4 refused not committed", dut_a.mem[2][7:0], 8'h5F);
    check("t4 held wr ready", ready_a, 1'b1);
    check("t4 held wr data", data_a, 8'h6B);
    drive_a(1'b0, 1'b0, 3'd0, 8'h00);
    check("t4 committed", dut_a.mem[2][7:0], 8'h6B);

    // Latency 3: read captures old data before a following write to the same address
    drive_b(1'b1, 1'b0, 3'd3, 8'hDE);
    drive_b(1'b1, 1'b1, 3'd3, 8'h00);
    check("t3 rvalid c0", rvalid_b, 1'b0);
    drive_b(1'b1, 1'b0, 3'd3, 8'h45);
    check("t3 wr ready", ready_b, 1'b1);
    check("t3 rvalid c1", rvalid_b, 1'b0);
    drive_b(1'b1, 1'b1, 3'd3, 8'h00);
    check("t3 rvalid c2", rvalid_b, 1'b0);
    drive_b(1'b0, 1'b0, 3'd0, 8'h00);
    check("t3 rvalid old", rvalid_b, 1'b1);
    check("t3 old data", data_b, 8'hDE);
    drive_b(1'b0, 1'b0, 3'd0, 8'h00);
    check("t3 rvalid gap", rvalid_b, 1'b0);
    drive_b(1'b0, 1'b0, 3'd0, 8'h00);
    check("t3 rvalid new", rvalid_b, 1'b1);
    check("t3 new data", data_b, 8'h45);
    drive_b(1'b0, 1'b0, 3'd0, 8'h00);
    check("t3 rvalid end", rvalid_b, 1'b0);

    // Address beyond DEPTH: write dropped, read returns zero with rvalid
    drive_b(1'b1, 1'b0, 3'd6, 8'hAA);
    drive_b(1'b1, 1'b1, 3'd6, 8'h00);
    drive_b(1'b0, 1'b0, 3'd0, 8'h00);
    drive_b(1'b0, 1'b0, 3'd0, 8'h00);
    drive_b(1'b0, 1'b0, 3'd0, 8'h00);
    check("oor rvalid", rvalid_b, 1'b1);
    check("oor data", data_b, 8'h00);

`ifdef MEM_PARITY_EN
    drive_a(1'b1, 1'b0, 3'd2, 8'hA5);
    drive_a(1'b0, 1'b0, 3'd0, 8'h00);
    flip_bit(2, 0);
    drive_a(1'b1, 1'b1, 3'd2, 8'h00);
    drive_a(1'b0, 1'b0, 3'd0, 8'h00);
    check("par rvalid", rvalid_a, 1'b1);
    check("par err set", perr_a, 1'b1);
    check("par data", data_a, 8'hA4);
    drive_a(1'b1, 1'b1, 3'd5, 8'h00);
    drive_a(1'b0, 1'b0, 3'd0, 8'h00);
    check("par other rvalid", rvalid_a, 1'b1);
    check("par other clean", perr_a, 1'b0);
`endif

    // Reset with two reads in flight on the latency-3 instance
    drive_b(1'b1, 1'b1, 3'd0, 8'h00);
    drive_b(1'b1, 1'b1, 3'd1, 8'h00);
    drive_b(1'b0, 1'b0, 3'd0, 8'h00);
    drive_b(1'b0, 1'b0, 3'd0, 8'h00);
    check("t5 rvalid before rst", rvalid_b, 1'b1);
    #1 reset = 1'b0;
    #1;
    check("t5 rvalid_b in rst", rvalid_b, 1'b0);
    check("t5 ready_b in rst", ready_b, 1'b0);
    check("t5 rvalid_a in rst", rvalid_a, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    cnt_a = 0; cnt_b = 0; stale_b = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!ready_a) cnt_a++;
      if (!ready_b) cnt_b++;
      if (rvalid_b) stale_b++;
    end
    check("t5 reclear a", cnt_a, 8);
    check("t5 reclear b", cnt_b, 6);
    check("t5 stale rvalid", stale_b, 0);

    drive_b(1'b1, 1'b1, 3'd3, 8'h00);
    drive_b(1'b0, 1'b0, 3'd0, 8'h00);
    drive_b(1'b0, 1'b0, 3'd0, 8'h00);
    drive_b(1'b0, 1'b0, 3'd0, 8'h00);
    check("t5 post rvalid", rvalid_b, 1'b1);
    check("t5 post cleared", data_b, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
